// File: rtl/seven_segments_pkg.sv
// Shared constants for the seven-segment reader: segment bit positions, glyph patterns, FSM states.
// The hex glyphs SEG_A..SEG_F are only decoded when SEG_READER_HEX_EN is defined.
package seven_segments_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_IDX_A = 0;
  localparam int SEG_IDX_B = 1;
  localparam int SEG_IDX_C = 2;
  localparam int SEG_IDX_D = 3;
  localparam int SEG_IDX_E = 4;
  localparam int SEG_IDX_F = 5;
  localparam int SEG_IDX_G = 6;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } reader_state_t;

endpackage

// File: rtl/seven_segments_pattern_to_digit.sv
// Combinational segment-pattern to digit decoder; unknown patterns give digit 0 with err set.
// Define SEG_READER_HEX_EN to also accept the A..F glyphs.
module seven_segments_pattern_to_digit
  import seven_segments_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic [3:0]       o_digit,
  output logic             o_err
);

  always_comb begin
    o_digit = 4'h0;
    o_err   = 1'b0;
    case (i_seg)
      SEG_0: o_digit = 4'h0;
      SEG_1: o_digit = 4'h1;
      SEG_2: o_digit = 4'h2;
      SEG_3: o_digit = 4'h3;
      SEG_4: o_digit = 4'h4;
      SEG_5: o_digit = 4'h5;
      SEG_6: o_digit = 4'h6;
      SEG_7: o_digit = 4'h7;
      SEG_8: o_digit = 4'h8;
      SEG_9: o_digit = 4'h9;
`ifdef SEG_READER_HEX_EN
      SEG_A: o_digit = 4'hA;
      SEG_B: o_digit = 4'hB;
      SEG_C: o_digit = 4'hC;
      SEG_D: o_digit = 4'hD;
      SEG_E: o_digit = 4'hE;
      SEG_F: o_digit = 4'hF;
`endif
      default: begin
        o_digit = 4'h0;
        o_err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_segments_reader.sv
// Recovers BCD digits from a multiplexed seven-segment bus and emits one frame per scan (valid/ready).
// Hex glyph decoding is enabled by defining SEG_READER_HEX_EN (see pattern_to_digit).
module seven_segments_reader
  import seven_segments_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    overrun
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam int               SMP_W   = NUM_DIGITS + SEG_W;

  logic [SMP_W-1:0]        r_prev;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_onehot;
  logic                    w_same;
  logic                    w_capture;
  logic [NUM_DIGITS-1:0]   w_cap_mask;

  logic [3:0]              w_dec_digit;
  logic                    w_dec_err;

  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_err;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [NUM_DIGITS-1:0]   w_seen_upd;
  logic [NUM_DIGITS-1:0]   w_seen_next;

  reader_state_t           r_state;
  reader_state_t           w_state_next;
  logic                    w_issue;
  logic                    w_accept;
  logic                    w_set_overrun;

  logic                    r_valid;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_overrun;

  seven_segments_pattern_to_digit u_decode (
    .i_seg   (seg_in),
    .o_digit (w_dec_digit),
    .o_err   (w_dec_err)
  );

  assign w_onehot = (an_in != '0) && ((an_in & (an_in - NUM_DIGITS'(1))) == '0);
  assign w_same   = ({an_in, seg_in} == r_prev);

  always_comb begin
    w_cnt_next = '0;
    if (w_onehot) begin
      if (w_same)
        w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
      else
        w_cnt_next = CNT_W'(1);
    end
  end

  // One capture per dwell: only the edge on which the counter first hits the limit.
  assign w_capture   = (w_cnt_next == CNT_MAX) && (r_cnt != CNT_MAX);
  assign w_cap_mask  = w_capture ? an_in : '0;
  assign w_seen_upd  = r_seen | w_cap_mask;
  assign w_seen_next = w_issue ? w_cap_mask : w_seen_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= {an_in, seg_in};
      r_cnt  <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow     <= '0;
      r_shadow_err <= '0;
      r_seen       <= '0;
    end else begin
      r_seen <= w_seen_next;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_cap_mask[i]) begin
          r_shadow[4*i +: 4] <= w_dec_digit;
          r_shadow_err[i]    <= w_dec_err;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= COLLECT;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_issue       = 1'b0;
    w_accept      = 1'b0;
    w_set_overrun = 1'b0;
    case (r_state)
      COLLECT: begin
        if (&r_seen) begin
          w_issue      = 1'b1;
          w_state_next = PRESENT;
        end
      end
      PRESENT: begin
        // A second scan completing while the first is still unconsumed.
        if (!(&r_seen) && (&w_seen_upd))
          w_set_overrun = 1'b1;
        if (frame_ready) begin
          w_accept     = 1'b1;
          w_state_next = COLLECT;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_digits  <= '0;
      r_err     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_issue) begin
        r_valid  <= 1'b1;
        r_digits <= r_shadow;
        r_err    <= r_shadow_err;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_set_overrun)
        r_overrun <= 1'b1;
    end
  end

  assign frame_valid  = r_valid;
  assign frame_digits = r_digits;
  assign frame_err    = r_err;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_seven_segments_reader.sv
// Bench for seven_segments_reader: directed scans plus random dwells against a behavioural model.
// Honours SEG_READER_HEX_EN so it matches whichever decoder build is compiled.
`timescale 1ns/1ps
module tb_seven_segments_reader;

  localparam int ND = 4;
  localparam int SC = 4;
`ifdef SEG_READER_HEX_EN
  localparam int N_DEC = 16;
`else
  localparam int N_DEC = 10;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg_in = '0;
  logic [ND-1:0]   an_in = '0;
  logic            frame_ready = 1'b0;
  logic            frame_valid;
  logic [4*ND-1:0] frame_digits;
  logic [ND-1:0]   frame_err;
  logic            overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seven_segments_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .an_in        (an_in),
    .frame_ready  (frame_ready),
    .frame_valid  (frame_valid),
    .frame_digits (frame_digits),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  logic [6:0] pat_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Behavioural model state
  int              m_run;
  logic [10:0]     m_last;
  logic [ND-1:0]   m_seen;
  logic [3:0]      m_shadow [ND];
  logic [ND-1:0]   m_shadow_err;
  logic            m_valid;
  logic            m_over;
  logic [4*ND-1:0] m_frame;
  logic [ND-1:0]   m_ferr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] model_decode(input logic [6:0] s);
    for (int k = 0; k < N_DEC; k++)
      if (pat_tbl[k] == s) return {k[3:0], 1'b0};
    return 5'b00001;
  endfunction

  task automatic model_reset();
    m_run = 0; m_last = '0; m_seen = '0; m_shadow_err = '0;
    m_valid = 1'b0; m_over = 1'b0; m_frame = '0; m_ferr = '0;
    for (int k = 0; k < ND; k++) m_shadow[k] = 4'h0;
  endtask

  task automatic model_step();
    logic [10:0] smp;
    logic        oh;
    logic        was_full;
    logic        was_valid;
    logic [4:0]  dec;
    smp       = {an_in, seg_in};
    oh        = $onehot(an_in);
    was_full  = &m_seen;
    was_valid = m_valid;
    if (oh && smp == m_last) m_run++;
    else m_run = oh ? 1 : 0;
    m_last = smp;
    if (!was_valid) begin
      if (was_full) begin
        for (int k = 0; k < ND; k++) m_frame[4*k +: 4] = m_shadow[k];
        m_ferr  = m_shadow_err;
        m_valid = 1'b1;
        m_seen  = '0;
      end
    end else if (frame_ready) begin
      m_valid = 1'b0;
    end
    if (m_run == SC) begin
      dec = model_decode(seg_in);
      for (int k = 0; k < ND; k++) begin
        if (an_in[k]) begin
          m_shadow[k]     = dec[4:1];
          m_shadow_err[k] = dec[0];
          m_seen[k]       = 1'b1;
        end
      end
    end
    if (was_valid && !was_full && (&m_seen)) m_over = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cyc_valid",   frame_valid,  m_valid);
        check("cyc_digits",  frame_digits, m_frame);
        check("cyc_err",     frame_err,    m_ferr);
        check("cyc_overrun", overrun,      m_over);
      end
    end
  end

  task automatic dwell(input logic [ND-1:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    an_in  = a;
    seg_in = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    dwell(4'b0001, s0, SC);
    dwell(4'b0010, s1, SC);
    dwell(4'b0100, s2, SC);
    dwell(4'b1000, s3, SC);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    an_in  = '0;
    seg_in = '0;
    while (!frame_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, frame_valid, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid",   frame_valid,  1'b0);
    check("rst_digits",  frame_digits, 16'h0000);
    check("rst_err",     frame_err,    4'h0);
    check("rst_overrun", overrun,      1'b0);
    #2 rst_n = 1'b1;

    // basic scan, ready high
    frame_ready = 1'b1;
    scan(7'h3F, 7'h06, 7'h5B, 7'h4F);
    wait_valid("t1_valid");
    check("t1_digits",  frame_digits, 16'h3210);
    check("t1_err",     frame_err,    4'h0);
    check("t1_overrun", overrun,      1'b0);
    @(negedge clk);
    check("t1_pulse", frame_valid, 1'b0);

    // glitch rejection and multi-hot enables
    dwell(4'b0001, 7'h3F, 3);
    dwell(4'b0001, 7'h06, 4);
    dwell(4'b0011, 7'h3F, 10);
    dwell(4'b0010, 7'h5B, 4);
    dwell(4'b0100, 7'h4F, 4);
    dwell(4'b1000, 7'h66, 4);
    wait_valid("t2_valid");
    check("t2_digits", frame_digits, 16'h4321);
    check("t2_err",    frame_err,    4'h0);

    // blank pattern on digit 2
    dwell(4'b0100, 7'h00, 4);
    dwell(4'b0001, 7'h6D, 4);
    dwell(4'b0010, 7'h7D, 4);
    dwell(4'b1000, 7'h07, 4);
    wait_valid("t3_valid");
    check("t3_digits", frame_digits, 16'h7065);
    check("t3_err",    frame_err,    4'b0100);

    // backpressure across two scans
    @(negedge clk);
    frame_ready = 1'b0;
    scan(7'h3F, 7'h06, 7'h5B, 7'h4F);
    wait_valid("t4_valid1");
    check("t4_digits1", frame_digits, 16'h3210);
    scan(7'h6F, 7'h7F, 7'h07, 7'h7D);
    dwell(4'b0000, 7'h00, 2);
    check("t4_held_valid",   frame_valid,  1'b1);
    check("t4_held_digits",  frame_digits, 16'h3210);
    check("t4_overrun",      overrun,      1'b1);
    frame_ready = 1'b1;
    wait_valid("t4_valid2");
    check("t4_digits2",  frame_digits, 16'h6789);
    check("t4_overrun2", overrun,      1'b1);

    // reset with a held frame and a partial scan pending
    @(negedge clk);
    frame_ready = 1'b0;
    scan(7'h06, 7'h06, 7'h06, 7'h06);
    wait_valid("t5_valid_pre");
    dwell(4'b0001, 7'h5B, 4);
    dwell(4'b0010, 7'h5B, 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid",   frame_valid,  1'b0);
    check("t5_rst_digits",  frame_digits, 16'h0000);
    check("t5_rst_err",     frame_err,    4'h0);
    check("t5_rst_overrun", overrun,      1'b0);
    an_in = '0;
    seg_in = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    frame_ready = 1'b1;
    dwell(4'b0001, 7'h6D, 4);
    dwell(4'b0010, 7'h6D, 4);
    dwell(4'b0100, 7'h6D, 4);
    dwell(4'b0000, 7'h00, 10);
    check("t5_no_frame", frame_valid, 1'b0);
    dwell(4'b1000, 7'h6F, 4);
    wait_valid("t5_valid");
    check("t5_digits", frame_digits, 16'h9555);

    // hex glyph on digit 0
    scan(7'h77, 7'h06, 7'h5B, 7'h4F);
    wait_valid("t6_valid");
`ifdef SEG_READER_HEX_EN
    check("t6_digits", frame_digits, 16'h321A);
    check("t6_err",    frame_err,    4'b0000);
`else
    check("t6_digits", frame_digits, 16'h3210);
    check("t6_err",    frame_err,    4'b0001);
`endif

    // random dwells, checked every cycle against the model
    for (int t = 0; t < 400; t++) begin
      logic [ND-1:0] a;
      logic [6:0]    s;
      int            r;
      r = $urandom_range(0, 9);
      if (r < 8)       a = ND'(1) << $urandom_range(0, ND - 1);
      else if (r == 8) a = '0;
      else             a = ND'($urandom());
      if ($urandom_range(0, 7) == 0) s = 7'($urandom());
      else                           s = pat_tbl[$urandom_range(0, 15)];
      frame_ready = ($urandom_range(0, 2) != 0);
      dwell(a, s, $urandom_range(1, 7));
    end
    dwell(4'b0000, 7'h00, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
